// File: rtl/pixel_colour_scanner_if.sv
// Pixel colour scanner stream bundle.
// Carries the iteration-count input stream (iter_in/iter_valid/iter_ready,
// max_iter), the coloured pixel output stream (r/g/b, eol, sof, valid_out,
// out_ready) and the frame_done pulse.
//   slave  : view taken by the scanner itself
//   master : view taken by the surrounding logic (source and sink)
interface pixel_colour_scanner_if #(
  parameter int unsigned ITER_W = 8
);
  logic [ITER_W-1:0] iter_in;
  logic              iter_valid;
  logic              iter_ready;
  logic [ITER_W-1:0] max_iter;
  logic [7:0]        r_out;
  logic [7:0]        g_out;
  logic [7:0]        b_out;
  logic              eol_out;
  logic              sof_out;
  logic              valid_out;
  logic              out_ready;
  logic              frame_done;

  modport slave (
    input  iter_in, iter_valid, max_iter, out_ready,
    output iter_ready, r_out, g_out, b_out, eol_out, sof_out, valid_out, frame_done
  );

  modport master (
    output iter_in, iter_valid, max_iter, out_ready,
    input  iter_ready, r_out, g_out, b_out, eol_out, sof_out, valid_out, frame_done
  );
endinterface

// File: rtl/pixel_colour_scanner.sv
// Pixel colour scanner: maps escape-iteration counts, arriving in raster
// order, to RGB colours and tags each pixel with start-of-frame and
// end-of-line flags. One-deep registered output stage with a ready/valid
// handshake on both sides.
// Ports:
//   aclk   - clock, rising edge
//   areset - synchronous reset, active-high
//   bus    - pixel_colour_scanner_if.slave (input stream, output stream,
//            max_iter, frame_done)
// Parameters: WIDTH (pixels per line), HEIGHT (lines per frame),
//   ITER_W (iteration-count width, must be >= 8).
// Build option: COLOUR_CYCLE_EN - when defined, the palette index offset
//   advances by one at every frame end so the palette rotates per frame.
module pixel_colour_scanner #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned ITER_W = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  pixel_colour_scanner_if.slave  bus
);

  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic          valid_q;
  logic [7:0]    r_q;
  logic [7:0]    g_q;
  logic [7:0]    b_q;
  logic          eol_q;
  logic          sof_q;
  logic          last_row_q;
  logic          frame_done_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  logic          iter_ready_c;
  logic          accept_c;
  logic          consume_c;
  logic          frame_end_c;
  logic          x_last_c;
  logic          y_last_c;
  logic [7:0]    offset_c;
  logic [7:0]    idx_c;
  logic          in_set_c;
  logic [7:0]    r_c;
  logic [7:0]    g_c;
  logic [7:0]    b_c;

  // Handshakes; the output stage can refill in the same cycle it drains.
  assign iter_ready_c = !valid_q || bus.out_ready;
  assign accept_c     = bus.iter_valid && iter_ready_c;
  assign consume_c    = valid_q && bus.out_ready;
  // Last pixel of the frame leaving downstream.
  assign frame_end_c  = consume_c && eol_q && last_row_q;

  assign x_last_c = (x_q == X_LAST);
  assign y_last_c = (y_q == Y_LAST);

`ifdef COLOUR_CYCLE_EN
  logic [7:0] offset_q;

  // Palette rotation, stepped on the same edge that raises frame_done.
  always_ff @(posedge aclk) begin
    if (areset) begin
      offset_q <= 8'd0;
    end else if (frame_end_c) begin
      offset_q <= offset_q + 8'd1;
    end
  end

  assign offset_c = offset_q;
`else
  assign offset_c = 8'd0;
`endif

  // Colour lookup for the pixel being accepted this cycle.
  always_comb begin
    idx_c    = bus.iter_in[7:0] + offset_c;
    in_set_c = (bus.iter_in >= bus.max_iter);
    r_c      = 8'd0;
    g_c      = 8'd0;
    b_c      = 8'd0;
    if (!in_set_c) begin
      r_c = idx_c;
      g_c = {idx_c[6:0], 1'b0};
      b_c = 8'd255 - idx_c;
    end
  end

  // Output stage and raster position counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      valid_q      <= 1'b0;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      b_q          <= 8'd0;
      eol_q        <= 1'b0;
      sof_q        <= 1'b0;
      last_row_q   <= 1'b0;
      frame_done_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      frame_done_q <= frame_end_c;
      if (accept_c) begin
        valid_q    <= 1'b1;
        r_q        <= r_c;
        g_q        <= g_c;
        b_q        <= b_c;
        eol_q      <= x_last_c;
        sof_q      <= (x_q == '0) && (y_q == '0);
        last_row_q <= y_last_c;
        if (x_last_c) begin
          x_q <= '0;
          y_q <= y_last_c ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end else if (consume_c) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.iter_ready = iter_ready_c;
  assign bus.valid_out  = valid_q;
  assign bus.r_out      = r_q;
  assign bus.g_out      = g_q;
  assign bus.b_out      = b_q;
  assign bus.eol_out    = eol_q;
  assign bus.sof_out    = sof_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_colour_scanner.sv
// Testbench for pixel_colour_scanner on a 4x2 frame with 10-bit counts.
module tb_pixel_colour_scanner;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned IW = 10;
`ifdef COLOUR_CYCLE_EN
  localparam bit CYCLE = 1'b1;
`else
  localparam bit CYCLE = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       eol;
    logic       sof;
  } pix_t;

  logic aclk;
  logic areset;
  pixel_colour_scanner_if #(.ITER_W(IW)) bus ();

  pixel_colour_scanner #(.WIDTH(W), .HEIGHT(H), .ITER_W(IW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int   n_cmp;
  int   n_fail;
  pix_t exp_q[$];
  bit   last_q[$];
  int   n_acc;
  int   frames;
  bit   fd_pend;

  // Reference colour/position of the n-th accepted pixel since reset.
  function automatic pix_t model(input logic [IW-1:0] it, input logic [IW-1:0] mx,
                                 input int n, input int fr);
    pix_t p;
    int   pos;
    int   off;
    int   idx;
    pos = n % (W * H);
    off = CYCLE ? (fr % 256) : 0;
    idx = (int'(it[7:0]) + off) % 256;
    p = '0;
    if (it < mx) begin
      p.r = 8'(idx);
      p.g = 8'((idx * 2) % 256);
      p.b = 8'(255 - idx);
    end
    p.eol = ((pos % W) == W - 1);
    p.sof = (pos == 0);
    return p;
  endfunction

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    bus.iter_valid = 1'b0;
    bus.out_ready  = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    exp_q.delete();
    last_q.delete();
    n_acc   = 0;
    frames  = 0;
    fd_pend = 1'b0;
  endtask

  // One clock cycle: sample outputs, drive inputs, update the model queue.
  task automatic tick(input logic v, input logic [IW-1:0] it, input logic [IW-1:0] mx,
                      input logic ordy, output logic ov, output pix_t obs,
                      output logic rdy, output logic acc, output logic cons,
                      output pix_t exp, output logic exp_ok,
                      output logic fd_obs, output logic fd_exp);
    bit lst;
    @(negedge aclk);
    ov     = bus.valid_out;
    obs    = {bus.r_out, bus.g_out, bus.b_out, bus.eol_out, bus.sof_out};
    fd_obs = bus.frame_done;
    fd_exp = fd_pend;
    exp_ok = (exp_q.size() != 0);
    exp    = '0;
    bus.iter_valid = v;
    bus.iter_in    = it;
    bus.max_iter   = mx;
    bus.out_ready  = ordy;
    #1;
    rdy  = bus.iter_ready;
    acc  = v && rdy;
    cons = ov && ordy;
    fd_pend = 1'b0;
    if (cons && exp_ok) begin
      exp = exp_q.pop_front();
      lst = last_q.pop_front();
      fd_pend = lst;
    end
    if (acc) begin
      exp_q.push_back(model(it, mx, n_acc, frames));
      last_q.push_back((n_acc % (W * H)) == (W * H - 1));
      n_acc++;
    end
    if (fd_pend) frames++;
  endtask

  task automatic test_reset();
    @(negedge aclk);
    areset = 1'b1;
    bus.iter_valid = 1'b1;
    bus.iter_in    = IW'(7);
    bus.max_iter   = IW'(100);
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    #1;
    n_cmp++;
    if ({bus.valid_out, bus.r_out, bus.g_out, bus.b_out, bus.eol_out, bus.sof_out, bus.frame_done} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b rgb=%h%h%h eol=%b sof=%b fd=%b want all 0",
               bus.valid_out, bus.r_out, bus.g_out, bus.b_out, bus.eol_out, bus.sof_out, bus.frame_done);
    end
    n_cmp++;
    if (bus.iter_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_iter_ready: got %b want 1", bus.iter_ready);
    end
    areset = 1'b0;
    bus.iter_valid = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if (bus.valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: got valid_out=%b want 0", bus.valid_out);
    end
    exp_q.delete();
    last_q.delete();
    n_acc = 0; frames = 0; fd_pend = 1'b0;
  endtask

  task automatic test_frame();
    logic ov, rdy, acc, cons, exp_ok, fd_obs, fd_exp;
    pix_t obs, exp;
    int   k, fd_cnt;
    do_reset();
    k = 0; fd_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      tick(i < 8, IW'($urandom_range(0, 1023)), IW'($urandom_range(0, 1023)), 1'b1,
           ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
      if (fd_obs === 1'b1) fd_cnt++;
      n_cmp++;
      if (fd_obs !== fd_exp || fd_obs !== (i == 9)) begin
        n_fail++;
        $display("FAIL frame_done_timing: cycle %0d got %b want %b", i, fd_obs, (i == 9));
      end
      if (cons) begin
        n_cmp++;
        if (!exp_ok || obs !== exp) begin
          n_fail++;
          $display("FAIL frame_pixel: pixel %0d got %h want %h", k, obs, exp);
        end
        n_cmp++;
        if ({obs.sof, obs.eol} !== {k == 0, (k % 4) == 3}) begin
          n_fail++;
          $display("FAIL frame_flags: pixel %0d got sof/eol %b%b want %b%b",
                   k, obs.sof, obs.eol, k == 0, (k % 4) == 3);
        end
        k++;
      end
    end
    n_cmp++;
    if (fd_cnt != 1 || k != 8) begin
      n_fail++;
      $display("FAIL frame_counts: got pulses=%0d pixels=%0d want 1 and 8", fd_cnt, k);
    end
  endtask

  task automatic test_colour();
    logic ov, rdy, acc, cons, exp_ok, fd_obs, fd_exp;
    pix_t obs, exp;
    logic [IW-1:0] its [5];
    logic [IW-1:0] mxs [5];
    logic [23:0]   rgb [5];
    int k;
    its = '{IW'(100), IW'(5), IW'(99), IW'('h105), IW'('h3FF)};
    mxs = '{IW'(100), IW'(100), IW'(100), IW'('h200), IW'('h3FF)};
    rgb = '{24'h000000, 24'h050AFA, 24'h63C69C, 24'h050AFA, 24'h000000};
    do_reset();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      tick(i < 5, (i < 5) ? its[i] : IW'(0), (i < 5) ? mxs[i] : IW'(0), 1'b1,
           ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
      if (cons && k < 5) begin
        n_cmp++;
        if ({obs.r, obs.g, obs.b} !== rgb[k] || !exp_ok || obs !== exp) begin
          n_fail++;
          $display("FAIL colour: pixel %0d got %h want %h", k, {obs.r, obs.g, obs.b}, rgb[k]);
        end
        k++;
      end
    end
    n_cmp++;
    if (k != 5) begin
      n_fail++;
      $display("FAIL colour_count: got %0d want 5", k);
    end
  endtask

  task automatic test_backpressure();
    logic ov, rdy, acc, cons, exp_ok, fd_obs, fd_exp;
    pix_t obs, exp, held;
    logic [IW-1:0] a, b;
    a = IW'($urandom_range(0, 255));
    b = IW'($urandom_range(0, 255));
    do_reset();
    tick(1'b1, a, IW'(300), 1'b1, ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
    held = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, b, IW'(300), 1'b0, ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
      if (i == 0) held = obs;
      n_cmp++;
      if (rdy !== 1'b0 || ov !== 1'b1 || obs !== held) begin
        n_fail++;
        $display("FAIL hold: cycle %0d got rdy=%b v=%b pix=%h want rdy=0 v=1 pix=%h",
                 i, rdy, ov, obs, held);
      end
    end
    tick(1'b1, b, IW'(300), 1'b1, ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
    n_cmp++;
    if (!cons || !acc || !exp_ok || obs !== exp) begin
      n_fail++;
      $display("FAIL hold_release: got cons=%b acc=%b pix=%h want 1 1 %h", cons, acc, obs, exp);
    end
    tick(1'b0, IW'(0), IW'(300), 1'b1, ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
    n_cmp++;
    if (ov !== 1'b1 || !exp_ok || obs !== exp) begin
      n_fail++;
      $display("FAIL hold_next: got v=%b pix=%h want v=1 pix=%h", ov, obs, exp);
    end
    tick(1'b0, IW'(0), IW'(300), 1'b1, ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
    n_cmp++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got valid_out=%b want 0", ov);
    end
  endtask

  task automatic test_back_to_back();
    logic ov, rdy, acc, cons, exp_ok, fd_obs, fd_exp;
    pix_t obs, exp;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      tick(i < 24, IW'($urandom_range(0, 1023)), IW'($urandom_range(0, 1023)), 1'b1,
           ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
      n_cmp++;
      if (acc !== (i < 24) || cons !== (i >= 1 && i <= 24)) begin
        n_fail++;
        $display("FAIL b2b_flow: cycle %0d got acc=%b cons=%b want %b %b",
                 i, acc, cons, i < 24, i >= 1 && i <= 24);
      end
      if (cons) begin
        n_cmp++;
        if (!exp_ok || obs !== exp) begin
          n_fail++;
          $display("FAIL b2b_pixel: cycle %0d got %h want %h", i, obs, exp);
        end
      end
      n_cmp++;
      if (fd_obs !== fd_exp) begin
        n_fail++;
        $display("FAIL b2b_frame_done: cycle %0d got %b want %b", i, fd_obs, fd_exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic ov, rdy, acc, cons, exp_ok, fd_obs, fd_exp;
    pix_t obs, exp;
    do_reset();
    for (int i = 0; i < 6; i++)
      tick(1'b1, IW'($urandom_range(0, 255)), IW'(300), 1'b1,
           ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
    do_reset();
    #1;
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_valid: got v=%b fd=%b want 0 0", bus.valid_out, bus.frame_done);
    end
    tick(1'b1, IW'(9), IW'(300), 1'b1, ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
    tick(1'b0, IW'(0), IW'(300), 1'b1, ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
    n_cmp++;
    if (!cons || obs.sof !== 1'b1 || !exp_ok || obs !== exp) begin
      n_fail++;
      $display("FAIL midreset_sof: got cons=%b pix=%h want sof=1 pix=%h", cons, obs, exp);
    end
  endtask

  task automatic test_random();
    logic ov, rdy, acc, cons, exp_ok, fd_obs, fd_exp;
    pix_t obs, exp;
    logic ordy;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ordy = (i >= 290) || ($urandom_range(0, 2) != 0);
      tick((i < 290) && ($urandom_range(0, 3) != 0), IW'($urandom_range(0, 1023)),
           IW'($urandom_range(0, 1023)), ordy,
           ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
      n_cmp++;
      if (rdy !== (!ov || ordy) || ov !== exp_ok) begin
        n_fail++;
        $display("FAIL rand_handshake: cycle %0d got rdy=%b v=%b want rdy=%b v=%b",
                 i, rdy, ov, !ov || ordy, exp_ok);
      end
      if (cons) begin
        n_cmp++;
        if (!exp_ok || obs !== exp) begin
          n_fail++;
          $display("FAIL rand_pixel: cycle %0d got %h want %h", i, obs, exp);
        end
      end
      n_cmp++;
      if (fd_obs !== fd_exp) begin
        n_fail++;
        $display("FAIL rand_frame_done: cycle %0d got %b want %b", i, fd_obs, fd_exp);
      end
    end
  endtask

  task automatic test_colour_cycle();
    logic ov, rdy, acc, cons, exp_ok, fd_obs, fd_exp;
    pix_t obs, exp;
    logic [23:0] want;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      want = (f == 1 && CYCLE) ? 24'h060CF9 : 24'h050AFA;
      for (int i = 0; i < 11; i++) begin
        tick(i < 8, IW'(5), IW'(100), 1'b1, ov, obs, rdy, acc, cons, exp, exp_ok, fd_obs, fd_exp);
        if (cons) begin
          n_cmp++;
          if ({obs.r, obs.g, obs.b} !== want || !exp_ok || obs !== exp) begin
            n_fail++;
            $display("FAIL colour_cycle: frame %0d got %h want %h", f, {obs.r, obs.g, obs.b}, want);
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    n_acc = 0; frames = 0; fd_pend = 1'b0;
    areset = 1'b1;
    bus.iter_valid = 1'b0;
    bus.iter_in    = '0;
    bus.max_iter   = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_frame();
    test_colour();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_colour_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pixel_colour_scanner.md
PIXEL_COLOUR_SCANNER -- requirements
Module: pixel_colour_scanner

Interface
REQ-001 Parameter WIDTH, default 640, active pixels per line.
REQ-002 Parameter HEIGHT, default 480, lines per frame.
REQ-003 Parameter ITER_W, default 8, iteration-count width; SHALL be at least 8.
REQ-004 aclk  input  1  the single clock; all logic is on its rising edge.
REQ-005 areset  input  1  synchronous reset, active-high.
REQ-006 iter_in  input  ITER_W  escape-iteration count of the next pixel in raster order.
REQ-007 iter_valid  input  1  iter_in is valid.
REQ-008 iter_ready  output  1  block accepts iter_in this cycle.
REQ-009 max_iter  input  ITER_W  iteration limit; it is sampled on every accepted pixel.
REQ-010 r_out, g_out, b_out  output  8 each  pixel colour.
REQ-011 eol_out  output  1  the current pixel is the last pixel of its line.
REQ-012 sof_out  output  1  the current pixel is the first pixel of the frame.
REQ-013 valid_out  output  1  r/g/b/eol/sof outputs are valid.
REQ-014 out_ready  input  1  downstream ready, driven by the stream packer's in_stream_ready.
REQ-015 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted downstream.

Function
REQ-016 Input handshake: a pixel is accepted when iter_valid && iter_ready; iter_ready = !valid_out || out_ready, which is combinational.
REQ-017 Output handshake: a pixel is consumed when valid_out && out_ready.
REQ-018 Latency: an accepted pixel appears on the outputs, with valid_out=1, on the next cycle.
REQ-019 While valid_out && !out_ready, every output SHALL hold stable and no input is accepted.
REQ-020 If a pixel is consumed and a new one accepted in the same cycle, the outputs update to the new pixel with no bubble.
REQ-021 If a pixel is consumed and none is accepted, valid_out falls to 0 on the next cycle.
REQ-022 Colour index idx = (iter_in[7:0] + offset) mod 256, where offset is defined under Configuration.
REQ-023 If iter_in >= max_iter (unsigned, full ITER_W), the pixel is in the set and {r,g,b} = {0,0,0}.
REQ-024 Otherwise r = idx, g = (idx << 1) mod 256, b = 255 - idx.
REQ-025 Position counters x (0..WIDTH-1) and y (0..HEIGHT-1) track the pixel being accepted.
REQ-026 sof_out = 1 iff x==0 && y==0 at acceptance.
REQ-027 eol_out = 1 iff x==WIDTH-1 at acceptance.
REQ-028 Counters advance only on input acceptance.
REQ-029 x wraps to 0 after WIDTH-1, and y increments at that point.
REQ-030 y wraps to 0 after HEIGHT-1, at the same point x wraps.
REQ-031 frame_done = 1 for exactly one cycle, the cycle after a consumed pixel with eol_out=1 whose y was HEIGHT-1.
REQ-032 Counter widths are clog2 of WIDTH and HEIGHT; no arithmetic overflow beyond the wrap is permitted.

Reset
REQ-033 While areset=1, on each clock: valid_out=0, r/g/b=0, eol_out=0, sof_out=0, frame_done=0, x=0, y=0, offset=0.
REQ-034 During reset, iter_ready=1 (because valid_out=0), but no pixel is accepted.
REQ-035 A reset asserted mid-frame discards the held pixel; the first pixel accepted after reset carries sof_out=1.

Configuration
REQ-036 Macro COLOUR_CYCLE_EN.
- Defined: an 8-bit offset register increments by 1, mod 256, in the same cycle frame_done is set, so the palette rotates each frame.
- Not defined: offset is constant 0 and no offset register exists.

Verification
REQ-037 WIDTH=4, HEIGHT=2, out_ready=1, 8 iter_in values streamed -> sof_out only on pixel 0; eol_out on pixels 3 and 7; frame_done pulses once, one cycle after pixel 7.
REQ-038 max_iter=100, iter_in=100 then 5 -> first pixel {0,0,0}; second pixel {5,10,250}.
REQ-039 Output held with out_ready=0 for 3 cycles and iter_valid=1 -> iter_ready=0; outputs unchanged; the next pixel appears one cycle after out_ready rises.
REQ-040 Continuous valid and ready -> one pixel per cycle, no bubbles; pixel order and colours preserved.
REQ-041 areset pulsed after pixel 5 of a 4x2 frame -> valid_out=0; next accepted pixel has sof_out=1.
REQ-042 COLOUR_CYCLE_EN defined, iter_in=5 in every pixel, 2 frames -> frame 0 colour {5,10,250}; frame 1 colour {6,12,249}; undefined -> both frames {5,10,250}.
